// File: rtl/clock_enable_gen.sv
// clock_enable_gen: multi-channel clock-enable strobe generator.
// Each channel counts master-clock edges and emits a one-cycle registered
// strobe every D = max(div, 1) active cycles. Per channel: programmable
// divisor with a shadow register applied only at period boundaries, a reset
// phase, and a halt input that defers (never drops) a pulse.
// Optional feature macro: CLKEN_CYCLE_COUNT_EN adds cycle_count_o, one 32-bit
// pulse counter per channel. With the macro undefined the port is absent.
//
// Divisor write interface: div_wr_i is a single-cycle write strobe with no
// back-pressure. Every edge that samples div_wr_i high writes div_val_i into
// the shadow of channel div_ch_i. Indices >= NUM_CH are dropped silently.
module clock_enable_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT   = {8'd24, 8'd4, 8'd12},
  parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT = {8'd0, 8'd0, 8'd0},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_CH-1:0]    halt_i,
  input  logic                 resync_i,
  input  logic                 div_wr_i,
  input  logic [CH_W-1:0]      div_ch_i,
  input  logic [CNT_W-1:0]     div_val_i,
`ifdef CLKEN_CYCLE_COUNT_EN
  output logic [NUM_CH*32-1:0] cycle_count_o,
`endif
  output logic [NUM_CH-1:0]    enable_o
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  div_q    [NUM_CH];
  logic [CNT_W-1:0]  div_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] en_d;
  logic [NUM_CH-1:0] wrap;

`ifdef CLKEN_CYCLE_COUNT_EN
  logic [31:0] cc_q [NUM_CH];
  logic [31:0] cc_d [NUM_CH];
`endif

  // Per-channel next state: shadow write, then resync > halt > wrap > count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic [CNT_W-1:0] last_cnt;
      logic             wr_hit;
      // Terminal count is D-1 with D = max(div, 1); 0 and 1 both give 0.
      last_cnt = (div_q[c] == '0) ? '0 : div_q[c] - CNT_W'(1);
      wr_hit   = div_wr_i && (div_ch_i == CH_W'(c));
      // A write on the same edge as a wrap or resync must reach div at once,
      // so the shadow's next value is what gets loaded.
      shadow_d[c] = wr_hit ? div_val_i : shadow_q[c];
      cnt_d[c]    = cnt_q[c];
      div_d[c]    = div_q[c];
      en_d[c]     = 1'b0;
      wrap[c]     = 1'b0;
      if (resync_i) begin
        cnt_d[c] = PHASE_INIT[c*CNT_W +: CNT_W];
        div_d[c] = shadow_d[c];
      end else if (halt_i[c]) begin
        cnt_d[c] = cnt_q[c];
      end else if (cnt_q[c] >= last_cnt) begin
        // >= so that an out-of-range phase wraps immediately.
        wrap[c]  = 1'b1;
        cnt_d[c] = '0;
        en_d[c]  = 1'b1;
        div_d[c] = shadow_d[c];
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
`ifdef CLKEN_CYCLE_COUNT_EN
      if (resync_i)     cc_d[c] = '0;
      else if (wrap[c]) cc_d[c] = cc_q[c] + 32'd1;
      else              cc_d[c] = cc_q[c];
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= PHASE_INIT[c*CNT_W +: CNT_W];
        div_q[c]    <= DIV_INIT[c*CNT_W +: CNT_W];
        shadow_q[c] <= DIV_INIT[c*CNT_W +: CNT_W];
`ifdef CLKEN_CYCLE_COUNT_EN
        cc_q[c]     <= '0;
`endif
      end
      en_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        div_q[c]    <= div_d[c];
        shadow_q[c] <= shadow_d[c];
`ifdef CLKEN_CYCLE_COUNT_EN
        cc_q[c]     <= cc_d[c];
`endif
      end
      en_q <= en_d;
    end
  end

  assign enable_o = en_q;

`ifdef CLKEN_CYCLE_COUNT_EN
  // Pack per-channel counters onto the flat output, ch0 in the LSBs.
  always_comb begin
    cycle_count_o = '0;
    for (int c = 0; c < NUM_CH; c++) cycle_count_o[c*32 +: 32] = cc_q[c];
  end
`endif

endmodule
